// File: rtl/dsp_ce_sequencer_if.sv
// Operand-in / result-out valid-ready handshake for dsp_ce_sequencer.
// master = producer/consumer side, slave = the sequencer.
interface dsp_ce_sequencer_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid
  );
endinterface

// File: rtl/dsp_ce_sequencer.sv
// Clock-enable / stage-reset sequencer for the DSP48A1 register stages, with valid-token tracking.
// Optional saturating output-stall counter when DSP_CE_STALL_CNT_EN is defined.
module dsp_ce_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  dsp_ce_sequencer_if.slave     hs,
  output logic [NUM_STAGES-1:0] ce,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  busy
`ifdef DSP_CE_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  logic [NUM_STAGES-1:0] v_q, v_d;
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic [NUM_STAGES:0]   ce_ext;     // ce_ext[NUM_STAGES] is the output handshake
  logic                  in_ready_c;
  logic                  run;

  assign run = rst & ~flush;

  // Enable chain walks from the output back to stage 0 so each stage sees
  // whether its downstream neighbour moves this cycle.
  always_comb begin
    logic carry;
    // NOTE: every variable written here gets a value first, so no latch is inferred.
    carry                  = run & v_q[NUM_STAGES-1] & hs.out_ready;
    ce_ext                 = '0;
    ce_ext[NUM_STAGES]     = carry;
    for (int i = NUM_STAGES - 1; i >= 1; i--) begin
      carry     = run & v_q[i-1] & (~v_q[i] | carry);
      ce_ext[i] = carry;
    end
    in_ready_c = run & (~v_q[0] | carry);
    ce_ext[0]  = hs.in_valid & in_ready_c;
  end

  always_comb begin
    v_d   = '0;
    occ_d = '0;
    if (run) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        v_d[i] = ce_ext[i] | (v_q[i] & ~ce_ext[i+1]);
      end
      occ_d = occ_q + CNT_W'(ce_ext[0]) - CNT_W'(ce_ext[NUM_STAGES]);
    end
  end

`ifdef DSP_CE_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (!run) begin
      stall_d = '0;
    end else if (hs.out_valid && !hs.out_ready && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

  // NOTE: reset is synchronous and all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
    end
  end

  // Gating with rst keeps outputs quiet even before the first reset edge.
  assign ce           = ce_ext[NUM_STAGES-1:0];
  assign stage_rst    = {NUM_STAGES{~rst | flush}};
  assign hs.in_ready  = in_ready_c;
  assign hs.out_valid = rst & v_q[NUM_STAGES-1];
  assign occupancy    = occ_q;
  assign busy         = rst & (occ_q != '0);

endmodule
